// File: rtl/sdr_iir_pkg.sv
// Shared width helpers for the receive-chain IIR averagers.
package sdr_iir_pkg;

  function automatic int max_width(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Accumulator keeps LGALPHA guard bits below the wider of input/output.
  function automatic int acc_width(input int iw, input int ow, input int lgalpha);
    return max_width(iw, ow) + lgalpha;
  endfunction

  localparam int DEF_IW      = 15;
  localparam int DEF_OW      = 16;
  localparam int DEF_LGALPHA = 4;
  localparam int DEF_AW      = acc_width(DEF_IW, DEF_OW, DEF_LGALPHA);

endpackage

// File: rtl/iiravg_sched_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched upward from a rotating pointer.
module iiravg_sched_rr_arbiter #(
  parameter int NCH   = 4,
  parameter int LGNCH = 2
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [NCH-1:0]   req,
  output logic [NCH-1:0]   grant,
  output logic [LGNCH-1:0] grant_idx,
  output logic             grant_any
);

  logic [LGNCH-1:0] ptr;

  always_comb begin
    int k;
    k         = 0;
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      k = (int'(ptr) + i) % NCH;
      if (!grant_any && req[k]) begin
        grant_any = 1'b1;
        grant[k]  = 1'b1;
        grant_idx = LGNCH'(k);
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)        ptr <= '0;
    else if (grant_any) ptr <= (int'(grant_idx) == NCH-1) ? '0 : grant_idx + 1'b1;
  end

endmodule

// File: rtl/iiravg_sched.sv
// Time-multiplexed NCH-channel IIR averager (alpha = 2^-LGALPHA), 3-stage result pipe.
// Optional IIRSCHED_PRELOAD_EN: first sample after reset/clear loads the accumulator directly.
import sdr_iir_pkg::*;

module iiravg_sched #(
  parameter int NCH     = 4,
  parameter int LGNCH   = 2,
  parameter int IW      = 15,
  parameter int OW      = 16,
  parameter int LGALPHA = 4,
  parameter int AW      = acc_width(IW, OW, LGALPHA),
  parameter logic [AW-1:0] RESET_VALUE = '0
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [NCH-1:0]    i_valid,
  input  logic [NCH*IW-1:0] i_data,
  output logic [NCH-1:0]    o_ready,
  input  logic              i_clear,
  input  logic [LGNCH-1:0]  i_clear_ch,
  output logic              o_valid,
  output logic [LGNCH-1:0]  o_chan,
  output logic [OW-1:0]     o_data
);

  localparam int PADW = AW - IW;

  logic [NCH-1:0][AW-1:0] acc;
  logic [3:1]             vld_pipe;
  logic [NCH-1:0]         busy, req, grant;
  logic [LGNCH-1:0]       gidx, s1_ch, s2_ch;
  logic                   gany, clr_ok;
  logic [IW-1:0]          s1_smp;
  logic [AW-1:0]          s1_acc, s2_acc, s2_adj, new_acc;
  logic signed [AW-1:0]   diff;
`ifdef IIRSCHED_PRELOAD_EN
  logic [IW-1:0]          s2_smp;
  logic [NCH-1:0]         primed;
`endif

  // A channel is held off while it sits in stage 1 or 2, so its next read sees the write-back.
  always_comb begin
    busy = '0;
    if (vld_pipe[1]) busy[s1_ch] = 1'b1;
    if (vld_pipe[2]) busy[s2_ch] = 1'b1;
  end

  assign req     = i_valid & ~busy & ~{NCH{i_reset}};
  assign o_ready = grant;
  assign o_valid = vld_pipe[3];
  assign clr_ok  = i_clear && (int'(i_clear_ch) < NCH);

  iiravg_sched_rr_arbiter #(.NCH(NCH), .LGNCH(LGNCH)) u_arb (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .req       (req),
    .grant     (grant),
    .grant_idx (gidx),
    .grant_any (gany)
  );

  assign diff = signed'({s1_smp, {PADW{1'b0}}} - s1_acc);

  always_comb begin
    new_acc = s2_acc + s2_adj;
`ifdef IIRSCHED_PRELOAD_EN
    if (!primed[s2_ch]) new_acc = {s2_smp, {PADW{1'b0}}};
`endif
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      vld_pipe <= '0;
      s1_ch    <= '0;
      s1_smp   <= '0;
      s1_acc   <= '0;
      s2_ch    <= '0;
      s2_acc   <= '0;
      s2_adj   <= '0;
      o_chan   <= '0;
      o_data   <= '0;
`ifdef IIRSCHED_PRELOAD_EN
      s2_smp   <= '0;
`endif
    end else begin
      vld_pipe <= {vld_pipe[2:1], gany};
      if (gany) begin
        s1_ch  <= gidx;
        s1_smp <= i_data[int'(gidx)*IW +: IW];
        s1_acc <= acc[gidx];
      end
      if (vld_pipe[1]) begin
        s2_ch  <= s1_ch;
        s2_acc <= s1_acc;
        s2_adj <= diff >>> LGALPHA;
`ifdef IIRSCHED_PRELOAD_EN
        s2_smp <= s1_smp;
`endif
      end
      if (vld_pipe[2]) begin
        o_chan <= s2_ch;
        o_data <= new_acc[AW-1 -: OW];
      end
    end
  end

  // Clear is written last so it overrides a same-edge write-back to that channel.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      acc <= {NCH{RESET_VALUE}};
`ifdef IIRSCHED_PRELOAD_EN
      primed <= '0;
`endif
    end else begin
      if (vld_pipe[2]) begin
        acc[s2_ch] <= new_acc;
`ifdef IIRSCHED_PRELOAD_EN
        primed[s2_ch] <= 1'b1;
`endif
      end
      if (clr_ok) begin
        acc[i_clear_ch] <= RESET_VALUE;
`ifdef IIRSCHED_PRELOAD_EN
        primed[i_clear_ch] <= 1'b0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_iiravg_sched.sv
// Directed bench for iiravg_sched; inputs change and outputs are sampled on the falling edge.
module tb_iiravg_sched;

  localparam int NCH = 4, LGNCH = 2, IW = 15, OW = 16;

  logic              i_clk = 1'b0;
  logic              i_reset, i_clear;
  logic [NCH-1:0]    i_valid, o_ready;
  logic [NCH*IW-1:0] i_data;
  logic [LGNCH-1:0]  i_clear_ch, o_chan;
  logic              o_valid;
  logic [OW-1:0]     o_data;

  int n_chk  = 0;
  int n_fail = 0;

  // Acc is 20 bits; o_data = acc[19:4]. 0x4000 pads to 0x80000, which is negative, so it wraps down.
  localparam logic [15:0] E1 [3] = '{16'hF800, 16'hF080, 16'hE978};
  localparam logic [15:0] E2 [8] = '{16'h0200, 16'h0400, 16'h0600, 16'h0100,
                                     16'h03E0, 16'h07C0, 16'h0BA0, 16'h01F0};
  localparam logic [15:0] E3 [5] = '{16'h0400, 16'h07C0, 16'h0B44, 16'h0A8F, 16'h09E6};
  localparam logic [15:0] E4 [3] = '{16'h0400, 16'h0400, 16'h07C0};
  localparam logic [3:0]  E5R [5] = '{4'b0001, 4'b0010, 4'b0000, 4'b0001, 4'b0010};

  iiravg_sched #(.NCH(NCH), .LGNCH(LGNCH), .IW(IW), .OW(OW), .LGALPHA(4)) dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_valid    (i_valid),
    .i_data     (i_data),
    .o_ready    (o_ready),
    .i_clear    (i_clear),
    .i_clear_ch (i_clear_ch),
    .o_valid    (o_valid),
    .o_chan     (o_chan),
    .o_data     (o_data)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_smp(input int k, input logic [IW-1:0] v);
    i_data[k*IW +: IW] = v;
  endtask

  // Leaves reset deasserted right at a falling edge: that edge is cycle 0 of the next test.
  task automatic do_reset();
    @(negedge i_clk);
    i_reset = 1'b1; i_valid = '0; i_clear = 1'b0; i_clear_ch = '0;
    @(negedge i_clk);
    @(negedge i_clk);
    i_reset = 1'b0;
  endtask

  initial begin
    i_reset = 1'b1; i_valid = '1; i_data = '0; i_clear = 1'b0; i_clear_ch = '0;
    repeat (2) @(negedge i_clk);
    #1;
    chk("rst_ready", 32'(o_ready), 32'h0);
    chk("rst_valid", 32'(o_valid), 32'h0);
    chk("rst_chan",  32'(o_chan),  32'h0);
    chk("rst_data",  32'(o_data),  32'h0);

`ifdef IIRSCHED_PRELOAD_EN
    do_reset();
    set_smp(3, 15'h1234);
    for (int c = 0; c < 10; c++) begin
      i_valid = (c < 9) ? 4'b1000 : 4'b0000;
      #1;
      chk("pre_ready", 32'(o_ready), (c < 9 && c % 3 == 0) ? 32'h8 : 32'h0);
      chk("pre_valid", 32'(o_valid), 32'(c >= 3 && c % 3 == 0));
      if (c >= 3 && c % 3 == 0) begin
        chk("pre_chan", 32'(o_chan), 32'd3);
        chk("pre_data", 32'(o_data), 32'h2468);
      end
      @(negedge i_clk);
    end
    i_clear = 1'b1; i_clear_ch = 2'd3;
    @(negedge i_clk);
    i_clear = 1'b0;
    set_smp(3, 15'h0100);
    i_valid = 4'b1000;
    #1;
    chk("pre2_ready", 32'(o_ready), 32'h8);
    @(negedge i_clk);
    i_valid = '0;
    @(negedge i_clk);
    @(negedge i_clk);
    #1;
    chk("pre2_valid", 32'(o_valid), 32'h1);
    chk("pre2_data",  32'(o_data),  32'h0200);
`else
    // Single channel, 0x4000 step on ch2
    do_reset();
    set_smp(2, 15'h4000);
    for (int c = 0; c < 10; c++) begin
      i_valid = (c < 9) ? 4'b0100 : 4'b0000;
      #1;
      chk("t1_ready", 32'(o_ready), (c < 9 && c % 3 == 0) ? 32'h4 : 32'h0);
      chk("t1_valid", 32'(o_valid), 32'(c >= 3 && c % 3 == 0));
      if (c >= 3 && c % 3 == 0) begin
        chk("t1_chan", 32'(o_chan), 32'd2);
        chk("t1_data", 32'(o_data), 32'(E1[c/3-1]));
      end
      @(negedge i_clk);
    end

    // All channels requesting: strict rotation
    do_reset();
    set_smp(0, 15'h1000); set_smp(1, 15'h2000); set_smp(2, 15'h3000); set_smp(3, 15'h0800);
    for (int c = 0; c < 11; c++) begin
      i_valid = (c < 8) ? 4'hF : 4'h0;
      #1;
      chk("t2_ready", 32'(o_ready), (c < 8) ? (32'h1 << (c % 4)) : 32'h0);
      chk("t2_valid", 32'(o_valid), 32'(c >= 3));
      if (c >= 3) begin
        chk("t2_chan", 32'(o_chan), 32'((c - 3) % 4));
        chk("t2_data", 32'(o_data), 32'(E2[c-3]));
      end
      @(negedge i_clk);
    end

    // Ch0 rises then steps to zero: adj must sign-extend
    do_reset();
    for (int c = 0; c < 16; c++) begin
      i_valid = (c < 13) ? 4'b0001 : 4'b0000;
      set_smp(0, (c < 9) ? 15'h2000 : 15'h0000);
      #1;
      chk("t3_ready", 32'(o_ready), (c < 13 && c % 3 == 0) ? 32'h1 : 32'h0);
      chk("t3_valid", 32'(o_valid), 32'(c >= 3 && c % 3 == 0));
      if (c >= 3 && c % 3 == 0) chk("t3_data", 32'(o_data), 32'(E3[c/3-1]));
      @(negedge i_clk);
    end

    // Clear ch1 on the same edge as its write-back
    do_reset();
    set_smp(1, 15'h2000);
    for (int c = 0; c < 10; c++) begin
      i_valid    = (c < 9) ? 4'b0010 : 4'b0000;
      i_clear    = (c == 2);
      i_clear_ch = 2'd1;
      #1;
      chk("t4_valid", 32'(o_valid), 32'(c >= 3 && c % 3 == 0));
      if (c >= 3 && c % 3 == 0) begin
        chk("t4_chan", 32'(o_chan), 32'd1);
        chk("t4_data", 32'(o_data), 32'(E4[c/3-1]));
      end
      @(negedge i_clk);
    end
    i_clear = 1'b0;

    // Async reset with two samples in flight
    do_reset();
    set_smp(0, 15'h2000); set_smp(1, 15'h2000);
    for (int c = 0; c < 5; c++) begin
      i_valid = 4'b0011;
      #1;
      chk("t5_ready", 32'(o_ready), 32'(E5R[c]));
      if (c >= 3) begin
        chk("t5_valid", 32'(o_valid), 32'h1);
        chk("t5_chan",  32'(o_chan),  32'(c - 3));
        chk("t5_data",  32'(o_data),  32'h0400);
      end
      @(negedge i_clk);
    end
    i_reset = 1'b1;
    #1;
    chk("t5_rst_valid", 32'(o_valid), 32'h0);
    chk("t5_rst_ready", 32'(o_ready), 32'h0);
    @(negedge i_clk);
    @(negedge i_clk);
    i_reset = 1'b0;
    i_valid = '0;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("t5_no_late", 32'(o_valid), 32'h0);
      @(negedge i_clk);
    end
    i_valid = 4'hF;
    #1;
    chk("t5_ptr0", 32'(o_ready), 32'h1);
    @(negedge i_clk);
    i_valid = '0;
    @(negedge i_clk);
    @(negedge i_clk);
    #1;
    chk("t5_acc_valid", 32'(o_valid), 32'h1);
    chk("t5_acc_chan",  32'(o_chan),  32'h0);
    chk("t5_acc_data",  32'(o_data),  32'h0400);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
